// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard, forwarding and memory-freeze control for the 5-stage RV32 pipeline
module hazard_ctrl #(
    parameter int          MEM_LAT = 2,
    parameter logic [1:0]  WB_MEM  = 2'b01,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic [1:0]       ex_wbsel,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwen,
    input  logic             mem_is_load,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwen,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             clear_f,
    output logic             clear_d,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam int              WC_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam logic            LAT_EN  = (MEM_LAT > 0);

    logic [0:0]       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_ld_done;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_freeze_start;
    logic w_freeze;
    logic w_wait_exit;
    logic w_redirect;
    logic w_lu_hit;
    logic w_load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_wen,
        input logic [4:0] w_rd,
        input logic       w_wen
    );
        if (rs != 5'd0 && m_wen && m_rd == rs)
            return 2'b01;
        else if (rs != 5'd0 && w_wen && w_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // ld_done blocks a second freeze while the same load still sits in MEM
    assign w_freeze_start = (r_state == RUN) && mem_is_load && !r_ld_done && LAT_EN;
    assign w_freeze       = w_freeze_start || (r_state == MEM_WAIT);
    assign w_wait_exit    = (w_freeze_start && (WC_LOAD == '0)) ||
                            ((r_state == MEM_WAIT) && (r_wait_cnt <= WC_W'(1)));

    assign w_lu_hit   = ex_regwen && (ex_wbsel == WB_MEM) && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign w_redirect = !w_freeze && ex_br_taken;
    assign w_load_use = !w_freeze && !ex_br_taken && w_lu_hit;

    // Reset forces bubbles into both stage registers without stalling
    always_comb begin
        stall_f = rst_n && (w_freeze || w_load_use);
        stall_d = rst_n && (w_freeze || w_load_use);
        stall_e = rst_n && w_freeze;
        clear_f = !rst_n || w_redirect;
        clear_d = !rst_n || w_redirect || w_load_use;
        fwd_a   = rst_n ? fwd_sel(id_rs1, mem_rd, mem_regwen, wb_rd, wb_regwen) : 2'b00;
        fwd_b   = rst_n ? fwd_sel(id_rs2, mem_rd, mem_regwen, wb_rd, wb_regwen) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_ld_done  <= 1'b0;
        end else begin
            if (!w_freeze)
                r_ld_done <= 1'b0;
            else if (w_wait_exit)
                r_ld_done <= 1'b1;

            case (r_state)
                RUN: begin
                    if (w_freeze_start && (WC_LOAD != '0)) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WC_LOAD;
                    end
                end
                default: begin
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                    if (w_wait_exit)
                        r_state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_f && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with directed scenarios and a randomized reference model
module tb_hazard_ctrl;

    localparam int         MEM_LAT = 2;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam int         CNT_W   = 4;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_regwen, ex_br_taken, mem_regwen, mem_is_load, wb_regwen;
    logic [1:0] ex_wbsel;
    logic stall_f, stall_d, stall_e, clear_f, clear_d;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [8:0] ctl;
    assign ctl = {stall_f, stall_d, stall_e, clear_f, clear_d, fwd_a, fwd_b};

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state: frozen cycles still owed, load-serviced flag, counter values
    int m_rem;
    bit m_ld;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(MEM_LAT), .WB_MEM(WB_MEM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_wbsel(ex_wbsel), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .clear_f(clear_f), .clear_d(clear_d), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_regwen && mem_rd == rs) return 2'b01;
        if (wb_regwen && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [8:0] m_ctl();
        bit frz, luc, br, lu;
        frz = (m_rem > 0) || (mem_is_load && !m_ld && MEM_LAT > 0);
        luc = ex_regwen && ex_wbsel == WB_MEM && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        br  = !frz && ex_br_taken;
        lu  = !frz && !ex_br_taken && luc;
        return {frz | lu, frz | lu, frz, br, br | lu, m_fwd(id_rs1), m_fwd(id_rs2)};
    endfunction

    task automatic m_edge();
        logic [8:0] c;
        c = m_ctl();
        if (c[8] && m_stall < CNT_MAX) m_stall++;
        if (c[5] && m_flush < CNT_MAX) m_flush++;
        if (c[6]) begin
            if (m_rem == 0) m_rem = MEM_LAT;
            m_rem--;
            if (m_rem == 0) m_ld = 1;
        end else begin
            m_ld = 0;
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_regwen = 0; ex_wbsel = 0; ex_br_taken = 0;
        mem_rd = 0; mem_regwen = 0; mem_is_load = 0; wb_rd = 0; wb_regwen = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        m_rem = 0; m_ld = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        ex_rd = r; ex_regwen = 1; ex_wbsel = WB_MEM; id_rs1 = r; id_use_rs1 = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        mem_rd = 3; mem_regwen = 1; id_rs1 = 3; ex_br_taken = 1; mem_is_load = 1;
        #2;
        n_cmp++;
        if (ctl !== 9'h030) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 9'h030);
        end
        n_cmp++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5);
        #1;
        n_cmp++;
        if (ctl !== 9'h190) begin
            n_fail++; $display("FAIL load_use_ctl: got %b want %b", ctl, 9'h190);
        end
        tick();
        idle();
        mem_rd = 5; mem_regwen = 1; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        n_cmp++;
        if (ctl !== 9'h004) begin
            n_fail++; $display("FAIL load_use_fwd: got %b want %b", ctl, 9'h004);
        end
        n_cmp++;
        if (stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_x0_unused();
        do_reset();
        ex_rd = 0; ex_regwen = 1; ex_wbsel = WB_MEM; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        n_cmp++;
        if (ctl !== 9'h000) begin
            n_fail++; $display("FAIL x0_load: got %b want %b", ctl, 9'h000);
        end
        ex_rd = 6; id_rs1 = 1; id_rs2 = 6; id_use_rs2 = 0;
        #1;
        n_cmp++;
        if (ctl !== 9'h000) begin
            n_fail++; $display("FAIL unused_rs2: got %b want %b", ctl, 9'h000);
        end
        id_use_rs2 = 1; ex_wbsel = 2'b00;
        #1;
        n_cmp++;
        if (ctl !== 9'h000) begin
            n_fail++; $display("FAIL non_load_ex: got %b want %b", ctl, 9'h000);
        end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        mem_rd = 7; wb_rd = 7; mem_regwen = 1; wb_regwen = 1; id_rs2 = 7;
        #1;
        n_cmp++;
        if (ctl !== 9'h001) begin
            n_fail++; $display("FAIL fwd_mem_prio: got %b want %b", ctl, 9'h001);
        end
        mem_regwen = 0;
        #1;
        n_cmp++;
        if (ctl !== 9'h002) begin
            n_fail++; $display("FAIL fwd_wb: got %b want %b", ctl, 9'h002);
        end
        mem_regwen = 1; mem_rd = 0; wb_rd = 0; id_rs2 = 0;
        #1;
        n_cmp++;
        if (ctl !== 9'h000) begin
            n_fail++; $display("FAIL fwd_x0: got %b want %b", ctl, 9'h000);
        end
    endtask

    task automatic test_freeze_redirect();
        do_reset();
        mem_is_load = 1; ex_br_taken = 1;
        set_load_use(5);
        #1;
        n_cmp++;
        if (ctl !== 9'h1C0) begin
            n_fail++; $display("FAIL freeze_c1: got %b want %b", ctl, 9'h1C0);
        end
        tick();
        n_cmp++;
        if (ctl !== 9'h1C0) begin
            n_fail++; $display("FAIL freeze_c2: got %b want %b", ctl, 9'h1C0);
        end
        tick();
        n_cmp++;
        if (ctl !== 9'h030 || stall_cnt !== 4'd2 || flush_cnt !== 4'd0) begin
            n_fail++; $display("FAIL freeze_end: got %b %0d/%0d want %b 2/0", ctl, stall_cnt, flush_cnt, 9'h030);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (ctl !== 9'h000 || stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
            n_fail++; $display("FAIL freeze_after: got %b %0d/%0d want %b 2/1", ctl, stall_cnt, flush_cnt, 9'h000);
        end
    endtask

    task automatic test_redirect_loaduse();
        do_reset();
        set_load_use(9);
        ex_br_taken = 1;
        #1;
        n_cmp++;
        if (ctl !== 9'h030) begin
            n_fail++; $display("FAIL redir_lu_ctl: got %b want %b", ctl, 9'h030);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd1) begin
            n_fail++; $display("FAIL redir_lu_cnt: got %0d/%0d want 0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n_frz;
        do_reset();
        mem_is_load = 1;
        #1;
        tick();
        n_cmp++;
        if (ctl !== 9'h1C0 || stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL wait_entry: got %b %0d want %b 1", ctl, stall_cnt, 9'h1C0);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if (ctl !== 9'h030 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_fail++; $display("FAIL wait_reset: got %b %0d/%0d want %b 0/0", ctl, stall_cnt, flush_cnt, 9'h030);
        end
        rst_n = 1;
        #1;
        n_frz = int'(stall_e);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_frz += int'(stall_e);
        end
        n_cmp++;
        if (n_frz != MEM_LAT || stall_cnt !== 4'd2) begin
            n_fail++; $display("FAIL wait_refreeze: got %0d cycles cnt %0d want %0d cycles cnt 2", n_frz, stall_cnt, MEM_LAT);
        end
        do_reset();
        #1;
        n_cmp++;
        if (stall_e !== 1'b0) begin
            n_fail++; $display("FAIL no_load_no_freeze: got %b want 0", stall_e);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use(4);
        repeat (CNT_MAX + 5) tick();
        ex_br_taken = 1;
        repeat (CNT_MAX + 5) tick();
        n_cmp++;
        if (stall_cnt !== CNT_W'(CNT_MAX) || flush_cnt !== CNT_W'(CNT_MAX)) begin
            n_fail++; $display("FAIL saturate: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, CNT_MAX, CNT_MAX);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_ctl;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3)); ex_regwen = 1'($urandom_range(0, 1));
            ex_wbsel = 2'($urandom_range(0, 3)); ex_br_taken = ($urandom_range(0, 7) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_regwen = 1'($urandom_range(0, 1));
            mem_is_load = ($urandom_range(0, 2) == 0);
            wb_rd = 5'($urandom_range(0, 3)); wb_regwen = 1'($urandom_range(0, 1));
            #1;
            exp_ctl = m_ctl();
            n_cmp++;
            if (ctl !== exp_ctl) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl, exp_ctl);
            end
            n_cmp++;
            if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            tick();
            m_edge();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_unused();
        test_fwd_priority();
        test_freeze_redirect();
        test_redirect_loaduse();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
